saturn_fetch: RTL and testbench

Nibble-serial instruction fetch unit for the Saturn core; it supplies the instruction decoder with one nibble per handshake. It reads nibbles over the synchronous Saturn memory bus into a small prefetch FIFO and tracks the program counter of the nibble being presented. It accepts redirects (jumps, returns, interrupts) from the execute stage, which flush the prefetch FIFO and restart fetching at the new address.

---
 rtl/saturn_fetch.sv | 81 ++++++++
 tb/tb_saturn_fetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/saturn_fetch.sv
// saturn_fetch: nibble-serial instruction fetch with prefetch FIFO and redirect (optional SATURN_FETCH_STATS_EN ack counter)
module saturn_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [19:0] RESET_ADDR = 20'h00000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic        o_bus_req,
    output logic [19:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [3:0]  i_bus_nibble,
    output logic [3:0]  o_nibble,
    output logic        o_nibble_valid,
    input  logic        i_nibble_ready,
    output logic [19:0] o_pc,
    input  logic        i_jump,
    input  logic [19:0] i_jump_addr
`ifdef SATURN_FETCH_STATS_EN
    ,
    output logic [31:0] o_fetch_count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
    typedef enum logic {RUN, HOLD} state_e;
    state_e             state_q, state_d;
    logic [19:0]        fetch_q, fetch_d, pc_q, pc_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic               push, pop;
    // Request is gated by the reset input so it drops the instant reset asserts.
    assign o_bus_req      = i_reset_n && state_q == RUN;
    assign push           = o_bus_req && i_bus_ack && !i_jump;
    assign pop            = o_nibble_valid && i_nibble_ready && !i_jump;
    assign o_nibble_valid = count_q != '0;
    assign o_nibble       = o_nibble_valid ? mem_q[rd_q] : 4'h0;
    assign o_bus_addr     = fetch_q;
    assign o_pc           = pc_q;
    // Next state: a jump flushes and redirects, otherwise push/pop advance independently.
    always_comb begin
        fetch_d = i_jump ? i_jump_addr : fetch_q + 20'(push);
        pc_d    = i_jump ? i_jump_addr : pc_q + 20'(pop);
        wr_d    = i_jump ? '0 : wr_q + PTR_W'(push);
        rd_d    = i_jump ? '0 : rd_q + PTR_W'(pop);
        count_d = i_jump ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        state_d = count_d == FULL ? HOLD : RUN;
    end
    // Control state with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= RUN;
            fetch_q <= RESET_ADDR;
            pc_q    <= RESET_ADDR;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // FIFO storage needs no reset; validity comes from the count.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= i_bus_nibble;
    end
`ifdef SATURN_FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    // Saturating count of accepted acks; survives jumps.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) fetch_count_q <= '0;
        else if (push && fetch_count_q != '1) fetch_count_q <= fetch_count_q + 32'd1;
    end
    assign o_fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_saturn_fetch.sv
// tb_saturn_fetch: directed and random checks of saturn_fetch against a queue-based model
module tb_saturn_fetch;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req, valid, ack = 1'b0, ready = 1'b0, jump = 1'b0;
    logic [19:0] bus_addr, pc, jaddr = '0;
    logic [3:0]  bus_nibble, nibble;
    logic [31:0] fetch_count;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  q[$];
    logic [19:0] m_fa, m_pc;
    logic [31:0] m_fc;

    always #5 clk = ~clk;

    function automatic logic [3:0] img(input logic [19:0] a);
        return 4'(a[3:0] + a[7:4]);
    endfunction

    assign bus_nibble = img(bus_addr);

    saturn_fetch #(.FIFO_DEPTH(DEPTH), .RESET_ADDR(20'h00000)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .o_bus_req(bus_req), .o_bus_addr(bus_addr),
        .i_bus_ack(ack), .i_bus_nibble(bus_nibble),
        .o_nibble(nibble), .o_nibble_valid(valid), .i_nibble_ready(ready),
        .o_pc(pc), .i_jump(jump), .i_jump_addr(jaddr)
`ifdef SATURN_FETCH_STATS_EN
        , .o_fetch_count(fetch_count)
`endif
    );
`ifndef SATURN_FETCH_STATS_EN
    assign fetch_count = '0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: compare what the DUT shows now, then predict the effect of the coming edge.
    always @(negedge clk) begin
        logic rq, vl;
        if (!rst_n) begin
            q.delete();
            m_fa = 20'h0;
            m_pc = 20'h0;
            m_fc = 0;
        end
        rq = rst_n && q.size() < DEPTH;
        vl = q.size() != 0;
        check("m_req", 32'(bus_req), 32'(rq));
        check("m_valid", 32'(valid), 32'(vl));
        check("m_nibble", 32'(nibble), vl ? 32'(q[0]) : 32'h0);
        check("m_pc", 32'(pc), 32'(m_pc));
        if (rq) check("m_addr", 32'(bus_addr), 32'(m_fa));
`ifdef SATURN_FETCH_STATS_EN
        check("m_fcount", fetch_count, m_fc);
`endif
        if (rst_n) begin
            if (jump) begin
                q.delete();
                m_fa = jaddr;
                m_pc = jaddr;
            end else begin
                if (vl && ready) begin
                    void'(q.pop_front());
                    m_pc = m_pc + 20'd1;
                end
                if (rq && ack) begin
                    q.push_back(img(m_fa));
                    m_fa = m_fa + 20'd1;
                    if (m_fc != '1) m_fc = m_fc + 1;
                end
            end
        end
    end

    task automatic step(input logic a, input logic r, input logic j, input logic [19:0] ja);
        ack = a;
        ready = r;
        jump = j;
        jaddr = ja;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        ack = 0;
        ready = 0;
        jump = 0;
        @(posedge clk);
        #3 rst_n = 0;
        @(posedge clk);
        #2 rst_n = 1;
        #1;
    endtask

    initial begin
        @(posedge clk);
        #3;
        check("rst_req", 32'(bus_req), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_nibble", 32'(nibble), 32'h0);
        @(posedge clk);
        #2 rst_n = 1;
        #1;
        check("first_req", 32'(bus_req), 32'h1);
        check("first_addr", 32'(bus_addr), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            check("seq_nibble", 32'(nibble), 32'(i));
            check("seq_pc", 32'(pc), 32'(i));
            check("seq_valid", 32'(valid), 32'h1);
        end
        reset_dut();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        check("full_req", 32'(bus_req), 32'h0);
        check("full_addr", 32'(bus_addr), 32'h4);
        step(1, 1, 0, 0);
        check("unfull_req", 32'(bus_req), 32'h1);
        check("unfull_pc", 32'(pc), 32'h1);
        check("unfull_nibble", 32'(nibble), 32'h1);
        step(1, 0, 1, 20'hFFFFE);
        check("jmp_valid", 32'(valid), 32'h0);
        check("jmp_req", 32'(bus_req), 32'h1);
        check("jmp_addr", 32'(bus_addr), 32'hFFFFE);
        check("jmp_pc", 32'(pc), 32'hFFFFE);
        step(1, 1, 0, 0);
        check("wrap0_nibble", 32'(nibble), 32'hD);
        check("wrap0_addr", 32'(bus_addr), 32'hFFFFF);
        step(1, 1, 0, 0);
        check("wrap1_nibble", 32'(nibble), 32'hE);
        check("wrap1_pc", 32'(pc), 32'hFFFFF);
        check("wrap1_addr", 32'(bus_addr), 32'h00000);
        step(1, 1, 0, 0);
        check("wrap2_pc", 32'(pc), 32'h00000);
        check("wrap2_nibble", 32'(nibble), 32'h0);
        reset_dut();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("pre_rst_pc", 32'(pc), 32'h1);
        #2 rst_n = 0;
        #1;
        check("async_req", 32'(bus_req), 32'h0);
        check("async_valid", 32'(valid), 32'h0);
        check("async_pc", 32'(pc), 32'h0);
        check("async_addr", 32'(bus_addr), 32'h0);
        @(posedge clk);
        #2 rst_n = 1;
        #1;
        step(1, 1, 0, 0);
        check("resume_nibble", 32'(nibble), 32'h0);
        check("resume_addr", 32'(bus_addr), 32'h1);
        for (int i = 0; i < 1000; i++) begin
            logic j;
            j = $urandom_range(0, 63) == 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, j, 20'($urandom));
        end
`ifdef SATURN_FETCH_STATS_EN
        reset_dut();
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 20'h12345);
        check("stats_count", fetch_count, 32'd10);
`endif
        step(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
